lsu: RTL

Load/store unit between the execute stage and the data memory. It accepts one memory request per handshake from the core and turns byte and halfword stores into a read-modify-write sequence, because the data memory only has a word-wide write port and no byte enables. It sign- or zero-extends sub-word load data and flags misaligned or illegal-size accesses. It returns one registered response per accepted request.

---
 rtl/lsu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// lsu -- load/store unit between execute and a word-wide data memory.
//
// Accepts one request per valid/ready handshake. Loads and word stores
// complete in one cycle. Byte/halfword stores become a read-modify-write:
// the current word is read and merged in the accept cycle, then written
// back in the following (RMW) cycle. Every accepted request produces
// exactly one registered single-cycle response pulse.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_*           core request (valid/ready, we, funct3, addr, wdata)
//   rsp_*           response pulse with extended load data and error flag
//   mem_*           data memory port (combinational read, write at next edge)
module lsu #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [2:0]    req_funct3_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [31:0]   mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          mem_write_o,
    output logic          mem_read_o,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        RMW  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] merge_reg, merge_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;

    logic [31:0] req_addr;
    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        req_err;
    logic        sub_store;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign req_addr = 32'(req_addr_i);

    assign req_ready_o = (state_reg != RMW);
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = (state_reg == RESP);
    assign rsp_rdata_o = rdata_reg;
    assign rsp_err_o   = err_reg;

    // Unsigned sizes (100/101) are meaningless for stores and are rejected.
    assign illegal    = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                        (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]);
    assign misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3_i == 3'b010) && (req_addr[1:0] != 2'b00));
    assign req_err    = illegal || misaligned;
    assign sub_store  = req_we_i && (req_funct3_i[1] == 1'b0);

    // Load lane extraction from the combinational read word.
    assign ld_byte = mem_rdata_i[{req_addr[1:0], 3'b000} +: 8];
    assign ld_half = req_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        ld_data = mem_rdata_i;
        case (req_funct3_i)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    // Store merge: each byte lane either keeps the memory byte or takes the
    // matching store byte. funct3[0] distinguishes halfword from byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = req_funct3_i[0] ? (req_addr[1] == gi[1])
                                              : (req_addr[1:0] == gi[1:0]);
            assign merged[8*gi +: 8] = !lane_hit ? mem_rdata_i[8*gi +: 8] :
                                       (req_funct3_i[0] ? req_wdata_i[8*(gi%2) +: 8]
                                                        : req_wdata_i[7:0]);
        end
    endgenerate

    always_comb begin
        state_next  = IDLE;
        addr_next   = addr_reg;
        merge_next  = merge_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;

        if (state_reg == RMW) begin
            // Write back the merged word from held registers only.
            mem_write_o = 1'b1;
            mem_addr_o  = addr_reg;
            mem_wdata_o = merge_reg;
            rdata_next  = 32'd0;
            err_next    = 1'b0;
            state_next  = RESP;
        end else if (accept) begin
            state_next = RESP;
            rdata_next = 32'd0;
            err_next   = req_err;
            if (!req_err) begin
                mem_addr_o = req_addr;
                if (!req_we_i) begin
                    mem_read_o = 1'b1;
                    rdata_next = ld_data;
                end else if (sub_store) begin
                    mem_read_o = 1'b1;
                    addr_next  = req_addr;
                    merge_next = merged;
                    state_next = RMW;
                end else begin
                    mem_write_o = 1'b1;
                    mem_wdata_o = req_wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= 32'd0;
            merge_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            merge_reg <= merge_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

endmodule
